// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, writeback-select encodings, the
// sequencer state type and the bundle of one-bit micro-op controls.
package decode_pkg;

  // Major opcodes, taken from ir[15:12]
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // Source of the value written to the destination register
  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_IMM = 2'd2,
    WB_PC  = 2'd3
  } mreg_wb_e;

  // Source of the value written to R7 (the program counter)
  typedef enum logic [2:0] {
    R7_NONE   = 3'd0,
    R7_MEM    = 3'd1,
    R7_BRANCH = 3'd2,
    R7_ALU    = 3'd3,
    R7_REG    = 3'd4
  } mr7wb_e;

  // IDLE accepts instructions; SEQ walks the remaining LM/SM register list
  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  // Per-micro-op control bundle; wmem is active-low (1 = no memory write)
  typedef struct packed {
    logic     mex1;
    logic     mex2;
    logic     alu_ctrl;
    logic     wmem;
    logic     mmem_r;
    logic     mmem_w;
    logic     mmem_data;
    mreg_wb_e mreg_wb;
    mr7wb_e   mr7wb;
  } ctrl_t;

  // Harmless bubble: no register, memory or R7 side effects
  localparam ctrl_t CTRL_NOP = '{
    mex1:      1'b0,
    mex2:      1'b0,
    alu_ctrl:  1'b0,
    wmem:      1'b1,
    mmem_r:    1'b0,
    mmem_w:    1'b0,
    mmem_data: 1'b0,
    mreg_wb:   WB_MEM,
    mr7wb:     R7_NONE
  };

  // True for the load/store-multiple opcodes that expand into micro-ops
  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant
// asserted request and whether any request was asserted at all.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit wins the last assignment
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_seq.sv
// Decode stage with LM/SM micro-op sequencer. Single-micro-op instructions
// appear on the registered outputs one cycle after acceptance; LM/SM are
// expanded into one micro-op per set bit of the register list, lowest first.
module decode_seq
  import decode_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] pc_imm,
  output logic [DATA_W-1:0] sext_imm6,
  output logic [DATA_W-1:0] imm970,
  output logic [RA_W-1:0]   ra1,
  output logic [RA_W-1:0]   ra2,
  output logic [RA_W-1:0]   wa,
  output logic              mex1,
  output logic              mex2,
  output logic              alu_ctrl,
  output logic              wmem,
  output logic              mmem_r,
  output logic              mmem_w,
  output logic              mmem_data,
  output logic [1:0]        mreg_wb,
  output logic [2:0]        mr7wb,
  output logic              uop_first,
  output logic              uop_last,
  output logic [RA_W-1:0]   uop_idx
);

  localparam logic [RA_W-1:0] REG_R7 = RA_W'(7);

  state_e          state;
  logic [NREG-1:0] list_q;
  ctrl_t           ctrl_q;

  logic            load;
  logic [DATA_W-1:0] src_ir;
  logic [3:0]      op;
  logic [RA_W-1:0] f_a, f_b, f_c;

  logic [NREG-1:0] enc_req;
  logic [RA_W-1:0] enc_idx;
  logic            enc_found;
  logic [NREG-1:0] one_hot;
  logic [NREG-1:0] list_rest;
  logic            more;

  ctrl_t           nx_ctrl;
  logic [RA_W-1:0] nx_ra1, nx_ra2, nx_wa;

  logic [DATA_W-1:0] sext6, sext9, nx_pc_imm, nx_imm970;

  // The output register may advance when empty or being drained downstream
  assign load     = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && load && !flush && !reset;

  prio_enc #(
    .N     (NREG),
    .IDX_W (RA_W)
  ) u_prio_enc (
    .req   (enc_req),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Select the instruction being decoded and the list feeding the encoder:
  // during SEQ the originating instruction is held in out_ir
  always_comb begin
    src_ir  = (state == SEQ) ? out_ir : ir;
    op      = src_ir[15:12];
    f_a     = RA_W'(src_ir[11:9]);
    f_b     = RA_W'(src_ir[8:6]);
    f_c     = RA_W'(src_ir[5:3]);
    enc_req = '0;
    if (state == SEQ) begin
      enc_req = list_q;
    end else if (is_multi(op)) begin
      enc_req = src_ir[NREG-1:0];
    end
    one_hot   = {{(NREG-1){1'b0}}, 1'b1} << enc_idx;
    list_rest = enc_req & ~one_hot;
    more      = enc_found && (list_rest != '0);
  end

  // Decode the next micro-op's register addresses and control bundle
  always_comb begin
    nx_ctrl = CTRL_NOP;
    nx_ra1  = '0;
    nx_ra2  = '0;
    nx_wa   = '0;
    case (op)
      OP_ADD, OP_NDU: begin
        nx_ra1           = f_a;
        nx_ra2           = f_b;
        nx_wa            = f_c;
        nx_ctrl.alu_ctrl = (op == OP_NDU);
        nx_ctrl.mreg_wb  = WB_ALU;
        nx_ctrl.mr7wb    = (f_c == REG_R7) ? R7_ALU : R7_NONE;
      end
      OP_ADI: begin
        nx_ra1          = f_a;
        nx_wa           = f_b;
        nx_ctrl.mex2    = 1'b1;
        nx_ctrl.mreg_wb = WB_ALU;
        nx_ctrl.mr7wb   = (f_b == REG_R7) ? R7_ALU : R7_NONE;
      end
      OP_LHI: begin
        nx_wa           = f_a;
        nx_ctrl.mreg_wb = WB_IMM;
      end
      OP_LW: begin
        nx_ra2          = f_b;
        nx_wa           = f_a;
        nx_ctrl.mex1    = 1'b1;
        nx_ctrl.mmem_r  = 1'b1;
        nx_ctrl.mreg_wb = WB_MEM;
        nx_ctrl.mr7wb   = (f_a == REG_R7) ? R7_MEM : R7_NONE;
      end
      OP_SW: begin
        nx_ra1         = f_a;
        nx_ra2         = f_b;
        nx_ctrl.mex1   = 1'b1;
        nx_ctrl.wmem   = 1'b0;
        nx_ctrl.mmem_w = 1'b1;
      end
      OP_LM: begin
        if (enc_found) begin
          nx_ra1          = f_a;
          nx_wa           = enc_idx;
          nx_ctrl.mmem_r  = 1'b1;
          nx_ctrl.mreg_wb = WB_MEM;
          nx_ctrl.mr7wb   = (enc_idx == REG_R7) ? R7_MEM : R7_NONE;
        end
      end
      OP_SM: begin
        if (enc_found) begin
          nx_ra1            = f_a;
          nx_ra2            = enc_idx;
          nx_ctrl.wmem      = 1'b0;
          nx_ctrl.mmem_w    = 1'b1;
          nx_ctrl.mmem_data = 1'b1;
        end
      end
      OP_BEQ: begin
        nx_ra1        = f_a;
        nx_ra2        = f_b;
        nx_ctrl.mr7wb = R7_BRANCH;
      end
      OP_JAL: begin
        nx_wa           = f_a;
        nx_ctrl.mreg_wb = WB_PC;
        nx_ctrl.mr7wb   = R7_BRANCH;
      end
      OP_JLR: begin
        nx_ra2          = f_b;
        nx_wa           = f_a;
        nx_ctrl.mreg_wb = WB_PC;
        nx_ctrl.mr7wb   = R7_REG;
      end
      default: ;
    endcase
  end

  // Immediates only matter on acceptance, so they are built from the input ir
  always_comb begin
    sext6     = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    sext9     = {{(DATA_W-9){ir[8]}}, ir[8:0]};
    nx_imm970 = {ir[8:0], {(DATA_W-9){1'b0}}};
    nx_pc_imm = pc + ((ir[15:12] == OP_JAL) ? sext9 : sext6);
  end

  // Sequencer state and output register; flush outranks accept and SEQ
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      list_q    <= '0;
      out_valid <= 1'b0;
      out_ir    <= '0;
      out_pc    <= '0;
      pc_imm    <= '0;
      sext_imm6 <= '0;
      imm970    <= '0;
      ra1       <= '0;
      ra2       <= '0;
      wa        <= '0;
      ctrl_q    <= CTRL_NOP;
      uop_first <= 1'b0;
      uop_last  <= 1'b0;
      uop_idx   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      list_q    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (state == SEQ) begin
        ra1       <= nx_ra1;
        ra2       <= nx_ra2;
        wa        <= nx_wa;
        ctrl_q    <= nx_ctrl;
        uop_first <= 1'b0;
        uop_last  <= !more;
        uop_idx   <= uop_idx + RA_W'(1);
        list_q    <= list_rest;
        out_valid <= 1'b1;
        if (!more) begin
          state <= IDLE;
        end
      end else if (in_valid) begin
        out_ir    <= ir;
        out_pc    <= pc;
        pc_imm    <= nx_pc_imm;
        sext_imm6 <= sext6;
        imm970    <= nx_imm970;
        ra1       <= nx_ra1;
        ra2       <= nx_ra2;
        wa        <= nx_wa;
        ctrl_q    <= nx_ctrl;
        uop_first <= 1'b1;
        uop_last  <= !more;
        uop_idx   <= '0;
        out_valid <= 1'b1;
        if (more) begin
          state  <= SEQ;
          list_q <= list_rest;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign mex1      = ctrl_q.mex1;
  assign mex2      = ctrl_q.mex2;
  assign alu_ctrl  = ctrl_q.alu_ctrl;
  assign wmem      = ctrl_q.wmem;
  assign mmem_r    = ctrl_q.mmem_r;
  assign mmem_w    = ctrl_q.mmem_w;
  assign mmem_data = ctrl_q.mmem_data;
  assign mreg_wb   = ctrl_q.mreg_wb;
  assign mr7wb     = ctrl_q.mr7wb;

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: table of single-micro-op instructions
// plus hand-written LM/SM, stall, flush and reset sequences.
module tb_decode_seq;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int RA_W   = 3;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DATA_W-1:0] ir, pc, out_ir, out_pc, pc_imm, sext_imm6, imm970;
  logic [RA_W-1:0]   ra1, ra2, wa, uop_idx;
  logic              mex1, mex2, alu_ctrl, wmem, mmem_r, mmem_w, mmem_data;
  logic [1:0]        mreg_wb;
  logic [2:0]        mr7wb;
  logic              uop_first, uop_last;

  always #5 clk = ~clk;

  decode_seq #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .pc_imm(pc_imm), .sext_imm6(sext_imm6),
    .imm970(imm970), .ra1(ra1), .ra2(ra2), .wa(wa), .mex1(mex1), .mex2(mex2),
    .alu_ctrl(alu_ctrl), .wmem(wmem), .mmem_r(mmem_r), .mmem_w(mmem_w),
    .mmem_data(mmem_data), .mreg_wb(mreg_wb), .mr7wb(mr7wb),
    .uop_first(uop_first), .uop_last(uop_last), .uop_idx(uop_idx)
  );

  // msk bits: {ra1, ra2, wa, mreg_wb, mr7wb} -- 1 = compare this field
  // ctl bits: {mex1, mex2, alu_ctrl, wmem, mmem_r, mmem_w, mmem_data}
  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [4:0]  msk;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  wa;
    logic [1:0]  mwb;
    logic [2:0]  mr7;
    logic [6:0]  ctl;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  int   lm_wa [4];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_sext6(input logic [15:0] i);
    return {{10{i[5]}}, i[5:0]};
  endfunction

  function automatic logic [15:0] m_imm970(input logic [15:0] i);
    return {i[8:0], 7'b0};
  endfunction

  function automatic logic [15:0] m_pc_imm(input logic [15:0] i, input logic [15:0] p);
    if (i[15:12] == 4'b1000) return p + {{7{i[8]}}, i[8:0]};
    return p + m_sext6(i);
  endfunction

  function automatic logic [6:0] ctl_now();
    return {mex1, mex2, alu_ctrl, wmem, mmem_r, mmem_w, mmem_data};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ir"},    32'(out_ir),    32'd0);
    check({tag, "_out_pc"},    32'(out_pc),    32'd0);
    check({tag, "_pc_imm"},    32'(pc_imm),    32'd0);
    check({tag, "_sext6"},     32'(sext_imm6), 32'd0);
    check({tag, "_imm970"},    32'(imm970),    32'd0);
    check({tag, "_regs"},      32'({ra1, ra2, wa}), 32'd0);
    check({tag, "_ctl"},       32'(ctl_now()), 32'b0001000);
    check({tag, "_wb"},        32'({mreg_wb, mr7wb}), 32'd0);
    check({tag, "_uop"},       32'({uop_first, uop_last, uop_idx}), 32'd0);
  endtask

  task automatic check_vec(input int n, input vec_t v);
    string t;
    t = $sformatf("v%0d", n);
    check({t, "_valid"},  32'(out_valid), 32'd1);
    check({t, "_out_ir"}, 32'(out_ir), 32'(v.ir));
    check({t, "_out_pc"}, 32'(out_pc), 32'(v.pc));
    check({t, "_sext6"},  32'(sext_imm6), 32'(m_sext6(v.ir)));
    check({t, "_imm970"}, 32'(imm970), 32'(m_imm970(v.ir)));
    check({t, "_pc_imm"}, 32'(pc_imm), 32'(m_pc_imm(v.ir, v.pc)));
    check({t, "_ctl"},    32'(ctl_now()), 32'(v.ctl));
    check({t, "_uop"},    32'({uop_first, uop_last, uop_idx}), 32'b11000);
    if (v.msk[4]) check({t, "_ra1"},     32'(ra1), 32'(v.ra1));
    if (v.msk[3]) check({t, "_ra2"},     32'(ra2), 32'(v.ra2));
    if (v.msk[2]) check({t, "_wa"},      32'(wa), 32'(v.wa));
    if (v.msk[1]) check({t, "_mreg_wb"}, 32'(mreg_wb), 32'(v.mwb));
    if (v.msk[0]) check({t, "_mr7wb"},   32'(mr7wb), 32'(v.mr7));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ir        pc        msk       ra1   ra2   wa    mwb   mr7   ctl
    vecs[0]  = '{16'h0238, 16'h0100, 5'b11111, 3'd1, 3'd0, 3'd7, 2'd1, 3'd3, 7'b0001000}; // ADD
    vecs[1]  = '{16'h2A51, 16'h0102, 5'b11111, 3'd5, 3'd1, 3'd2, 2'd1, 3'd0, 7'b0011000}; // NDU
    vecs[2]  = '{16'h1E85, 16'h0104, 5'b00100, 3'd0, 3'd0, 3'd2, 2'd0, 3'd0, 7'b0101000}; // ADI
    vecs[3]  = '{16'h3E12, 16'h0106, 5'b00110, 3'd0, 3'd0, 3'd7, 2'd2, 3'd0, 7'b0001000}; // LHI
    vecs[4]  = '{16'h4E43, 16'h0108, 5'b00011, 3'd0, 3'd0, 3'd0, 2'd0, 3'd1, 7'b1001100}; // LW R7
    vecs[5]  = '{16'h5283, 16'h010A, 5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 7'b1000010}; // SW
    vecs[6]  = '{16'hC2BF, 16'h0200, 5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 3'd2, 7'b0001000}; // BEQ
    vecs[7]  = '{16'h81FF, 16'h0010, 5'b00011, 3'd0, 3'd0, 3'd0, 2'd3, 3'd2, 7'b0001000}; // JAL -1
    vecs[8]  = '{16'h9180, 16'h0300, 5'b01011, 3'd0, 3'd6, 3'd0, 2'd3, 3'd4, 7'b0001000}; // JLR
    vecs[9]  = '{16'h6000, 16'h0400, 5'b00111, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 7'b0001000}; // LM empty
    vecs[10] = '{16'h7400, 16'h0402, 5'b00111, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 7'b0001000}; // SM empty
    vecs[11] = '{16'hF123, 16'h0404, 5'b00111, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 7'b0001000}; // undefined
    vecs[12] = '{16'h6A10, 16'h0406, 5'b10111, 3'd5, 3'd0, 3'd4, 2'd0, 3'd0, 7'b0001100}; // LM one bit
    vecs[13] = '{16'h7C80, 16'h0408, 5'b11001, 3'd6, 3'd7, 3'd0, 2'd0, 3'd0, 7'b0000011}; // SM one bit
    lm_wa = '{0, 2, 5, 7};

    reset = 1'b1; in_valid = 1'b0; ir = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_reset("rst");
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-micro-op instructions
    for (int i = 0; i < NVEC; i++) begin
      ir = vecs[i].ir; pc = vecs[i].pc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_vec(i, vecs[i]);
    end
    tick();
    check("tbl_drain_valid", 32'(out_valid), 32'd0);

    // LM list 0xA5: four micro-ops, in_ready low while sequencing
    ir = 16'h60A5; pc = 16'h0200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check($sformatf("lm%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("lm%0d_wa", k), 32'(wa), 32'(lm_wa[k]));
      check($sformatf("lm%0d_idx", k), 32'(uop_idx), 32'(k));
      check($sformatf("lm%0d_first_last", k), 32'({uop_first, uop_last}),
            32'({k == 0, k == 3}));
      check($sformatf("lm%0d_mr7wb", k), 32'(mr7wb), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("lm%0d_ra1_mmem_r", k), 32'({ra1, mmem_r, wmem}), 32'b00011);
      check($sformatf("lm%0d_out_ir", k), 32'(out_ir), 32'h60A5);
      check($sformatf("lm%0d_in_ready", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("lm_drain_valid", 32'(out_valid), 32'd0);

    // SM list 0x12 with a two-cycle downstream stall after micro-op 0
    ir = 16'h7612; pc = 16'h0300; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sm0_ra2", 32'(ra2), 32'd1);
    check("sm0_ctl", 32'({ra1, ctl_now()}), 32'({3'd3, 7'b0000011}));
    check("sm0_first_last", 32'({uop_first, uop_last}), 32'b10);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("sm_stall%0d_hold", k),
            32'({out_valid, ra2, uop_idx, uop_first, uop_last}),
            32'({1'b1, 3'd1, 3'd0, 1'b1, 1'b0}));
      check($sformatf("sm_stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("sm1_ra2", 32'(ra2), 32'd4);
    check("sm1_uop", 32'({out_valid, uop_first, uop_last, uop_idx}), 32'b101001);
    check("sm1_out_ir", 32'(out_ir), 32'h7612);
    tick();
    check("sm_drain_valid", 32'(out_valid), 32'd0);

    // LM list 0xFF flushed while micro-op 3 is on the outputs
    ir = 16'h60FF; pc = 16'h0500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("fl_uop3", 32'({out_valid, wa, uop_idx}), 32'({1'b1, 3'd3, 3'd3}));
    flush = 1'b1;
    #1;
    check("fl_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("fl_valid_low", 32'(out_valid), 32'd0);
    #1;
    check("fl_idle_in_ready", 32'(in_ready), 32'd1);
    ir = 16'h0238; pc = 16'h0600; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fl_next", 32'({out_valid, wa, uop_first, uop_last, uop_idx}),
          32'({1'b1, 3'd7, 1'b1, 1'b1, 3'd0}));
    check("fl_next_ir", 32'(out_ir), 32'h0238);
    tick();
    check("fl_no_stale_uop", 32'(out_valid), 32'd0);

    // Flush in the same cycle as an offered instruction blocks the accept
    ir = 16'h2A51; pc = 16'h0700; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("fa_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("fa_valid_low", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("fa_accept", 32'({out_valid, ra1, ra2, wa}), 32'({1'b1, 3'd5, 3'd1, 3'd2}));
    check("fa_out_ir", 32'(out_ir), 32'h2A51);
    tick();

    // Reset in the middle of an LM sequence
    ir = 16'h60FF; pc = 16'h0800; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rs_uop1", 32'({out_valid, wa, uop_idx}), 32'({1'b1, 3'd1, 3'd1}));
    reset = 1'b1;
    #1;
    check("rs_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_reset("rs");
    reset = 1'b0;
    ir = 16'h0238; pc = 16'h0900; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rs_next", 32'({out_valid, wa, uop_first, uop_last, uop_idx}),
          32'({1'b1, 3'd7, 1'b1, 1'b1, 3'd0}));
    tick();
    check("rs_drain_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
